// File: rtl/cnn_pkg.sv
// Shared CNN constants and the window byte-index helper.
// Also used by pe_incha_single so both agree on i_data layout.
package cnn_pkg;

  localparam int BYTE_W     = 8;
  localparam int KERNEL     = 3;
  localparam int KERNEL_PTS = 9;

  typedef enum logic {
    ST_SCAN,
    ST_EMIT
  } wg_state_e;

  // Byte slot of channel c, kernel row ky, kernel column kx.
  function automatic int byte_idx(
    input int c,
    input int ky,
    input int kx
  );
    return c * KERNEL_PTS + ky * KERNEL + kx;
  endfunction

endpackage

// File: rtl/window_gen_incha_if.sv
// Pixel stream in, 3x3 window out to the PE.
// slave is the window generator side, master the environment.
interface window_gen_incha_if
  import cnn_pkg::*;
#(
  parameter int IN_CHANNEL = 2
);

  localparam int PIX_W = BYTE_W * IN_CHANNEL;
  localparam int WIN_W = PIX_W * KERNEL_PTS;

  logic [PIX_W-1:0] i_data;
  logic             i_valid;
  logic             o_ready;
  logic [WIN_W-1:0] o_data;
  logic             o_valid;
  logic             pe_ready;
  logic             pe_ack;

  modport slave (
    input  i_data,
    input  i_valid,
    input  pe_ready,
    input  pe_ack,
    output o_ready,
    output o_data,
    output o_valid
  );

  modport master (
    output i_data,
    output i_valid,
    output pe_ready,
    output pe_ack,
    input  o_ready,
    input  o_data,
    input  o_valid
  );

endinterface

// File: rtl/line_buffer.sv
// Simple dual-port register array, one grid row deep.
// Reads are combinational, so a same-address write returns old data.
module line_buffer
  import cnn_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign rdata = mem_q[raddr];

  // Next array contents: one entry replaced on write.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/window_gen_incha.sv
// Streaming zero-padded 3x3 window generator feeding pe_incha_single.
// Walks an (H+1)x(W+1) grid; the extra row/column inject zero padding.
module window_gen_incha
  import cnn_pkg::*;
#(
  parameter int IN_WIDTH   = 3,
  parameter int IN_HEIGHT  = 3,
  parameter int IN_CHANNEL = 2,
  parameter int STRIDE     = 1
) (
  input logic               clk,
  input logic               rst_n,
  window_gen_incha_if.slave bus
);

  localparam int PIX_W = BYTE_W * IN_CHANNEL;
  localparam int WIN_W = PIX_W * KERNEL_PTS;
  localparam int XW    = $clog2(IN_WIDTH + 1);
  localparam int YW    = $clog2(IN_HEIGHT + 1);

  localparam logic [XW-1:0] X_LAST = XW'(IN_WIDTH);
  localparam logic [YW-1:0] Y_LAST = YW'(IN_HEIGHT);
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);

  wg_state_e        state_q, state_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [WIN_W-1:0] o_data_q, o_data_d;
  logic             o_valid_q, o_valid_d;
  logic [PIX_W-1:0] win_q [KERNEL][KERNEL];
  logic [PIX_W-1:0] win_d [KERNEL][KERNEL];
  logic [PIX_W-1:0] win_sh [KERNEL][KERNEL];

  logic             real_pos;
  logic             step;
  logic             emit_hit;
  logic             ready_c;
  logic [PIX_W-1:0] new_pix;
  logic [PIX_W-1:0] lb_y1_rd;
  logic [PIX_W-1:0] lb_y2_rd;
  logic [WIN_W-1:0] o_pack;
  logic [XW-1:0]    x_adv;
  logic [YW-1:0]    y_adv;

  assign real_pos = (y_q != Y_LAST) && (x_q != X_LAST);
  assign new_pix  = real_pos ? bus.i_data : '0;
  assign step     = (state_q == ST_SCAN)
                  && (!real_pos || bus.i_valid);
  assign emit_hit = (y_q != '0) && (x_q != '0)
                  && ((STRIDE == 1) || (y_q[0] && x_q[0]));

  assign bus.o_ready = ready_c;
  assign bus.o_data  = o_data_q;
  assign bus.o_valid = o_valid_q;

  line_buffer #(
    .DEPTH (IN_WIDTH + 1),
    .WIDTH (PIX_W)
  ) u_lb_y1 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (step),
    .waddr (x_q),
    .wdata (new_pix),
    .raddr (x_q),
    .rdata (lb_y1_rd)
  );

  line_buffer #(
    .DEPTH (IN_WIDTH + 1),
    .WIDTH (PIX_W)
  ) u_lb_y2 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (step),
    .waddr (x_q),
    .wdata (lb_y1_rd),
    .raddr (x_q),
    .rdata (lb_y2_rd)
  );

  // Raster advance of the grid counters with frame wrap.
  always_comb begin
    x_adv = x_q + XW'(1);
    y_adv = y_q;
    if (x_q == X_LAST) begin
      x_adv = '0;
      y_adv = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
    end
  end

  // Window after shifting in the current column.
  always_comb begin
    for (int ky = 0; ky < KERNEL; ky++) begin
      win_sh[ky][0] = win_q[ky][1];
      win_sh[ky][1] = win_q[ky][2];
    end
    win_sh[0][2] = lb_y2_rd;
    win_sh[1][2] = lb_y1_rd;
    win_sh[2][2] = new_pix;
    win_d = step ? win_sh : win_q;
  end

  // Pack the shifted window, zeroing the top row / left column
  // when they fall above or left of the image.
  always_comb begin
    o_pack = '0;
    for (int c = 0; c < IN_CHANNEL; c++) begin
      for (int ky = 0; ky < KERNEL; ky++) begin
        for (int kx = 0; kx < KERNEL; kx++) begin
          if (!((ky == 0 && y_q == Y_ONE)
                || (kx == 0 && x_q == X_ONE))) begin
            o_pack[BYTE_W*byte_idx(c, ky, kx) +: BYTE_W] =
              win_sh[ky][kx][BYTE_W*c +: BYTE_W];
          end
        end
      end
    end
  end

  // FSM next state, counters and output handshake.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    o_data_d  = o_data_q;
    o_valid_d = o_valid_q;
    ready_c   = 1'b0;
    unique case (state_q)
      ST_SCAN: begin
        ready_c = real_pos;
        if (step) begin
          if (emit_hit) begin
            state_d  = ST_EMIT;
            o_data_d = o_pack;
          end else begin
            x_d = x_adv;
            y_d = y_adv;
          end
        end
      end
      ST_EMIT: begin
        if (!o_valid_q) begin
          o_valid_d = bus.pe_ready;
        end else if (bus.pe_ack) begin
          o_valid_d = 1'b0;
          x_d       = x_adv;
          y_d       = y_adv;
          state_d   = ST_SCAN;
        end
      end
    endcase
  end

  // State, counter, window and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SCAN;
      x_q       <= '0;
      y_q       <= '0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
      for (int ky = 0; ky < KERNEL; ky++) begin
        for (int kx = 0; kx < KERNEL; kx++) begin
          win_q[ky][kx] <= '0;
        end
      end
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
      win_q     <= win_d;
    end
  end

endmodule

// File: doc/window_gen_incha.md
# window_gen_incha

Streaming 3x3 window generator that sits directly upstream of `pe_incha_single`. It accepts a raster-order pixel stream, where each pixel carries IN_CHANNEL bytes. From that stream it builds zero-padded 3x3 neighbourhoods (padding 1, stride 1 or 2) and presents each one to the PE as an `8*IN_CHANNEL*9`-bit vector. The byte layout matches the PE's `i_data` ordering, and each window is held under the PE's `pe_ready`/`pe_ack` handshake.

## Interface
- IN_WIDTH, 3: image width in pixels (≥2).
- IN_HEIGHT, 3: image height in pixels (≥2).
- IN_CHANNEL, 2: bytes per pixel.
- STRIDE, 1: window step, legal values are 1 or 2 (both axes).
- clk  input  1: clock; all state updates on rising edge.
- rst_n  input  1: reset, asynchronous and active-low.
- i_data  input  8*IN_CHANNEL: pixel; byte c = channel c.
- i_valid  input  1: pixel valid.
- o_ready  output  1: block accepts a pixel this cycle.
- o_data  output  8*IN_CHANNEL*9: window; byte index c*9 + ky*3 + kx.
- o_valid  output  1: window valid; connects to PE `i_valid`.
- pe_ready  input  1: PE idle.
- pe_ack  input  1: PE captured the window (single-cycle pulse).

## Operation
- **Scan grid:** the block walks a (IN_HEIGHT+1) x (IN_WIDTH+1) grid with counters y and x, in raster order.
  - Positions with y<IN_HEIGHT and x<IN_WIDTH are real: they consume one input pixel (i_valid && o_ready).
  - Positions with y==IN_HEIGHT or x==IN_WIDTH are injected: a zero pixel is used internally, one cycle each, and no input is consumed.
- **Storage:**
  - Two line buffers, depth IN_WIDTH+1, width 8*IN_CHANNEL. They hold grid rows y-1 and y-2.
  - A 3x3-column shift window.
  - At each grid position, the column {lb_row_y-2[x], lb_row_y-1[x], new} shifts into window column kx=2. The line buffers then advance.
- **Emission:** at grid position (y,x) with y≥1 and x≥1, the window centred at image pixel (y-1, x-1) is complete.
  - With STRIDE=2, a window is emitted only when (y-1) and (x-1) are both even.
- **Masking:** window row ky maps to image row y-2+ky, and column kx maps to x-2+kx. Any byte whose row or column is <0 is forced to 0. Right and bottom padding come from the injected zeros.
- **FSM:**
  - SCAN:
    - o_ready = 1 only at real positions.
    - A processed position with an emission pending goes to EMIT; otherwise the counters advance and the FSM stays in SCAN.
  - EMIT:
    - o_ready = 0; o_data is registered and frozen.
    - o_valid is set at the first edge where pe_ready=1. Once high, it stays high until a pe_ack edge, independent of pe_ready.
    - On pe_ack, o_valid clears, the counters advance, and the FSM returns to SCAN.
- **Frame wrap:** after position (IN_HEIGHT, IN_WIDTH) is processed and emitted, y and x return to 0 and the next frame begins immediately. Line buffers are not cleared; masking covers stale data.
- **Window count per frame:** IN_HEIGHT*IN_WIDTH for STRIDE=1; ceil(H/2)*ceil(W/2) for STRIDE=2.
- **Ignored/assumed inputs:**
  - pe_ack outside EMIT is ignored.
  - i_valid is ignored while o_ready=0.
  - i_data is not required to be held once accepted.

## Timing
- **Reset values:** state=SCAN, y=x=0, o_valid=0, o_data=0. o_ready evaluates to 1 immediately after reset.
- **Reset mid-frame:** in-flight pixels and windows are discarded. o_valid drops asynchronously, and the next accepted pixel is treated as (0,0).
- **Latency:** pixel accepted at edge N that completes a window, with pe_ready=1 → o_valid high after edge N+1.
- **Stall cost:** each injected position costs exactly one cycle. With no stalls, a 3x3 frame takes 16 grid cycles plus EMIT cycles.
- **Counter widths:** clog2(IN_WIDTH+1) for x and clog2(IN_HEIGHT+1) for y.
- **Line-buffer access:** read and write at the same address in the same cycle returns old data (read-before-write).

## Structure
- Shared package `cnn_pkg` holds BYTE_W=8, KERNEL=3, KERNEL_PTS=9 and the byte-index helper c*KERNEL_PTS+ky*KERNEL+kx. `pe_incha_single` uses the same helper.
- One sub-module, `line_buffer`: simple dual-port register array with read-before-write, instantiated twice.
- The FSM, counters, window registers and mask logic stay in `window_gen_incha`.

## Test plan
- **Stride 1, zero padding (top-left):** 3x3 image, IN_CHANNEL=2, ch0 = 1+3r+c, ch1 = 10+ch0, PE always ready and ack one cycle after o_valid → exactly 9 windows in raster order. The first has ch0 bytes [0,0,0,0,1,2,0,4,5] and ch1 bytes [0,0,0,0,11,12,0,14,15].
- **Stride 1, zero padding (bottom-right):** same run, last window ch0 = [5,6,0,8,9,0,0,0,0]. The centre window (1,1) has ch0 = [1..9].
- **Stride 2:** same image → 4 windows, centres (0,0), (0,2), (2,0), (2,2). The (0,2) window has ch0 = [0,0,0,2,3,0,5,6,0].
- **PE backpressure:** pe_ready low for 6 cycles, then pe_ack 5 cycles after o_valid rises → o_valid stays 0 until pe_ready, then holds high. o_data stays bit-stable and o_ready stays 0 throughout; window contents are unchanged from the no-stall run.
- **Input bubbles and back-to-back frames:** i_valid randomly 50% → identical window sequence. Two frames back-to-back → second frame's first window again has masked zeros (no stale rows leak).
- **Reset mid-frame:** rst_n pulsed low after the 4th window, while o_valid=1 → o_valid drops asynchronously and o_ready=1 after release. The next frame reproduces the first scenario exactly.
